// File: rtl/packet_scheduler.sv
// HDMI data-island slot arbiter: picks audio, ACR, InfoFrame or null packet per slot,
// keeps once-per-frame InfoFrame requests and counts frames where they were missed.
module packet_scheduler #(
    parameter bit AUDIO_ENABLE = 1'b1,
    parameter bit SPD_ENABLE   = 1'b1,
    parameter int AUDIO_BURST  = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       packet_enable,
    input  logic       audio_req,
    input  logic       acr_req,
    output logic [7:0] packet_type,
    output logic       audio_ack,
    output logic       acr_overrun,
    output logic [7:0] infoframe_miss_count
);

    localparam logic [7:0] TYPE_NULL  = 8'h00;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;
    localparam logic [3:0] BURST_MAX  = 4'(AUDIO_BURST);

    // Non-audio sources in priority order, index 0 highest: ACR, AVI, AIF, SPD.
    localparam logic [7:0] PEND_CODE [4] = '{8'h01, 8'h82, 8'h84, 8'h83};

    typedef enum logic {
        AUDIO_PHASE   = 1'b0,
        SERVICE_PHASE = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] pend_reg, pend_next;
    logic [3:0] burst_reg, burst_next;
    logic [7:0] packet_type_reg, packet_type_next;
    logic       audio_ack_reg;
    logic       acr_overrun_reg;
    logic [7:0] miss_count_reg;

    logic [3:0] pend_set;
    logic [4:0] higher_pend;
    logic [3:0] first_pend;
    logic [3:0] grant_mask;
    logic       grant_audio;
    logic       audio_ok;
    logic       other_pend;

    assign audio_ok   = audio_req & AUDIO_ENABLE;
    assign other_pend = |pend_reg;

    assign pend_set[0] = acr_req;
    assign pend_set[1] = frame_start;
    assign pend_set[2] = frame_start & AUDIO_ENABLE;
    assign pend_set[3] = frame_start & SPD_ENABLE;

    assign higher_pend[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            assign higher_pend[gi+1] = higher_pend[gi] | pend_reg[gi];
            assign first_pend[gi]    = pend_reg[gi] & ~higher_pend[gi];
            // A same-cycle set wins over the clear caused by a grant.
            assign pend_next[gi]     = pend_set[gi] | (pend_reg[gi] & ~grant_mask[gi]);
        end
    endgenerate

    always_comb begin
        grant_audio      = 1'b0;
        grant_mask       = 4'b0000;
        state_next       = state_reg;
        burst_next       = burst_reg;
        packet_type_next = packet_type_reg;
        if (packet_enable) begin
            case (state_reg)
                AUDIO_PHASE: begin
                    if (audio_ok && ((burst_reg < BURST_MAX) || !other_pend)) begin
                        grant_audio = 1'b1;
                        burst_next  = (burst_reg == 4'hF) ? 4'hF : burst_reg + 4'd1;
                    end else if (other_pend) begin
                        grant_mask = first_pend;
                        state_next = SERVICE_PHASE;
                        burst_next = 4'd0;
                    end else begin
                        burst_next = 4'd0;
                    end
                end
                SERVICE_PHASE: begin
                    state_next = AUDIO_PHASE;
                    if (audio_ok) begin
                        grant_audio = 1'b1;
                        burst_next  = 4'd1;
                    end else begin
                        grant_mask = first_pend;
                        burst_next = 4'd0;
                    end
                end
                default: state_next = AUDIO_PHASE;
            endcase

            packet_type_next = grant_audio ? TYPE_AUDIO : TYPE_NULL;
            for (int i = 0; i < 4; i++) begin
                if (grant_mask[i]) begin
                    packet_type_next = PEND_CODE[i];
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_reg       <= AUDIO_PHASE;
            pend_reg        <= 4'b0000;
            burst_reg       <= 4'd0;
            packet_type_reg <= TYPE_NULL;
            audio_ack_reg   <= 1'b0;
            acr_overrun_reg <= 1'b0;
            miss_count_reg  <= 8'd0;
        end else begin
            state_reg       <= state_next;
            pend_reg        <= pend_next;
            burst_reg       <= burst_next;
            packet_type_reg <= packet_type_next;
            audio_ack_reg   <= grant_audio;
            if (acr_req && pend_reg[0] && !grant_mask[0]) begin
                acr_overrun_reg <= 1'b1;
            end
            // Uses flags as they stood before this frame_start re-arms them.
            if (frame_start && (|pend_reg[3:1]) && (miss_count_reg != 8'hFF)) begin
                miss_count_reg <= miss_count_reg + 8'd1;
            end
        end
    end

    assign packet_type          = packet_type_reg;
    assign audio_ack            = audio_ack_reg;
    assign acr_overrun          = acr_overrun_reg;
    assign infoframe_miss_count = miss_count_reg;

endmodule
